// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator engine.
//   op_t    : operator codes carried on the oper input and the oper_latched output
//   state_t : engine FSM states
//   MAX_VAL : largest magnitude representable with a given number of decimal digits
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4,
        OP_NEG  = 3'd6
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        ARITH,
        MUL,
        DIV,
        CONV,
        DONE
    } state_t;

    // 10^digits - 1
    function automatic int unsigned MAX_VAL(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/calc_engine_if.sv
// Keypad / display bundle of the calculator engine.
//   master : keypad side, drives digit_valid/digit, oper_valid/oper, equals, clear
//            and observes bcd, negative, oper_latched, busy, err
//   slave  : the engine, the mirror image
interface calc_engine_if #(
    parameter int unsigned DIGITS = 3
);
    import calc_pkg::*;

    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  oper_valid;
    logic [2:0]            oper;
    logic                  equals;
    logic                  clear;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;
    op_t                   oper_latched;
    logic                  busy;
    logic                  err;

    modport master (
        output digit_valid, digit, oper_valid, oper, equals, clear,
        input  bcd, negative, oper_latched, busy, err
    );

    modport slave (
        input  digit_valid, digit, oper_valid, oper, equals, clear,
        output bcd, negative, oper_latched, busy, err
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   abort      : drop any conversion in progress
//   start      : load bin and begin; restarts a running conversion
//   bin        : binary magnitude to convert
//   done       : high during the cycle that performs the last shift step;
//                bcd holds the complete result from the following cycle on
//   bcd        : BCD result, digit 0 in bits [3:0]
module bin2bcd_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned MAG_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    input  logic                start,
    input  logic [MAG_W-1:0]    bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int unsigned CNT_W = $clog2(MAG_W + 1);

    logic [MAG_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;

    // add-3 correction on every digit that would reach 10 or more after the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= CNT_W'(MAG_W);
            run_q <= 1'b1;
        end else if (run_q) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done = run_q && (cnt_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator engine: decimal entry, sign-magnitude add/sub/mul/div with
// left-to-right chaining, sequential BCD conversion of the result.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : calc_engine_if.slave -- keypad pulses in; bcd, negative,
//           oper_latched, busy, err out
module calc_engine #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned MAG_W  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_engine_if.slave bus
);
    import calc_pkg::*;

    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned STEP_W = $clog2(MAG_W);
    localparam logic [CNT_W-1:0]   DIG_CNT   = CNT_W'(DIGITS);
    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(MAG_W - 1);
    localparam logic [2*MAG_W-1:0] MAX_2W    = (2*MAG_W)'(MAX_VAL(DIGITS));

    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
        $error("calc_engine: DIGITS must be in 1..6");
    end
    if ((64'd1 << MAG_W) <= 64'(MAX_VAL(DIGITS))) begin : g_bad_mag_w
        $error("calc_engine: MAG_W too narrow for DIGITS");
    end

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                neg_q, neg_d;
    op_t                 oper_q, oper_d;
    op_t                 pend_q, pend_d;        // operator latched when the result lands
    logic [MAG_W-1:0]    a_mag_q, a_mag_d;
    logic                a_neg_q, a_neg_d;
    logic [MAG_W-1:0]    disp_q, disp_d;        // binary shadow of the displayed magnitude
    logic [MAG_W-1:0]    res_mag_q, res_mag_d;
    logic                res_neg_q, res_neg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;          // digits in the current entry
    logic                fresh_q, fresh_d;      // next digit starts a new entry
    logic                entered_q, entered_d;  // an operand was keyed since the operator
    logic                err_q, err_d;
    logic [2*MAG_W-1:0]  acc_q, acc_d;
    logic [2*MAG_W-1:0]  mcand_q, mcand_d;
    logic [MAG_W-1:0]    mplier_q, mplier_d;
    logic [MAG_W-1:0]    rem_q, rem_d;
    logic [MAG_W-1:0]    quo_q, quo_d;
    logic [MAG_W-1:0]    dvsr_q, dvsr_d;
    logic [STEP_W-1:0]   step_q, step_d;

    // datapath helpers
    logic                b_neg_eff;
    logic [MAG_W:0]      arith_mag;
    logic                arith_neg;
    logic [2*MAG_W-1:0]  acc_nxt;
    logic [MAG_W:0]      rem_sh;
    logic [MAG_W-1:0]    rem_nx;
    logic [MAG_W-1:0]    quo_nx;

    // control helpers
    logic                launch;
    op_t                 launch_pend;
    logic                fin;
    logic                fin_bad;
    logic                fin_neg;
    logic [2*MAG_W-1:0]  fin_mag;
    logic [4*DIGITS-1:0] base_bcd;
    logic [MAG_W-1:0]    base_mag;
    logic [CNT_W-1:0]    base_cnt;
    logic                base_neg;

    logic                conv_start;
    logic [MAG_W-1:0]    conv_bin;
    logic                conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .MAG_W  (MAG_W)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (bus.clear),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // sign-magnitude add/sub, one shift-add step, one restoring-divide step
    always_comb begin
        b_neg_eff = neg_q ^ (oper_q == OP_SUB);
        if (a_neg_q == b_neg_eff) begin
            arith_mag = {1'b0, a_mag_q} + {1'b0, disp_q};
            arith_neg = a_neg_q;
        end else if (a_mag_q >= disp_q) begin
            arith_mag = {1'b0, a_mag_q - disp_q};
            arith_neg = a_neg_q;
        end else begin
            arith_mag = {1'b0, disp_q - a_mag_q};
            arith_neg = b_neg_eff;
        end

        acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        rem_sh = {rem_q, quo_q[MAG_W-1]};
        if (rem_sh >= {1'b0, dvsr_q}) begin
            rem_nx = rem_sh[MAG_W-1:0] - dvsr_q;
            quo_nx = {quo_q[MAG_W-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[MAG_W-1:0];
            quo_nx = {quo_q[MAG_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        neg_d       = neg_q;
        oper_d      = oper_q;
        pend_d      = pend_q;
        a_mag_d     = a_mag_q;
        a_neg_d     = a_neg_q;
        disp_d      = disp_q;
        res_mag_d   = res_mag_q;
        res_neg_d   = res_neg_q;
        cnt_d       = cnt_q;
        fresh_d     = fresh_q;
        entered_d   = entered_q;
        err_d       = err_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        step_d      = step_q;
        conv_start  = 1'b0;
        conv_bin    = '0;
        launch      = 1'b0;
        launch_pend = OP_NONE;
        fin         = 1'b0;
        fin_bad     = 1'b0;
        fin_neg     = 1'b0;
        fin_mag     = '0;

        // a digit after an operator or a result starts from an empty display
        base_bcd = fresh_q ? '0 : bcd_q;
        base_mag = fresh_q ? '0 : disp_q;
        base_cnt = fresh_q ? '0 : cnt_q;
        base_neg = fresh_q ? 1'b0 : neg_q;

        if (bus.clear) begin
            state_d   = IDLE;
            bcd_d     = '0;
            neg_d     = 1'b0;
            oper_d    = OP_NONE;
            pend_d    = OP_NONE;
            a_mag_d   = '0;
            a_neg_d   = 1'b0;
            disp_d    = '0;
            cnt_d     = '0;
            fresh_d   = 1'b0;
            entered_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!err_q) begin
                        if (bus.equals) begin
                            if (oper_q != OP_NONE) begin
                                launch      = 1'b1;
                                launch_pend = OP_NONE;
                            end
                        end else if (bus.oper_valid) begin
                            case (bus.oper)
                                OP_NEG: begin
                                    if (disp_q != '0) begin
                                        neg_d = ~neg_q;
                                    end
                                end
                                OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                                    if (oper_q == OP_NONE) begin
                                        a_mag_d   = disp_q;
                                        a_neg_d   = neg_q;
                                        oper_d    = op_t'(bus.oper);
                                        fresh_d   = 1'b1;
                                        entered_d = 1'b0;
                                    end else if (entered_q) begin
                                        launch      = 1'b1;
                                        launch_pend = op_t'(bus.oper);
                                    end else begin
                                        oper_d = op_t'(bus.oper);
                                    end
                                end
                                default: ;
                            endcase
                        end else if (bus.digit_valid && (bus.digit <= 4'd9)) begin
                            // a zero keyed into an empty entry still counts as an operand
                            bcd_d     = base_bcd;
                            disp_d    = base_mag;
                            cnt_d     = base_cnt;
                            neg_d     = base_neg;
                            fresh_d   = 1'b0;
                            entered_d = 1'b1;
                            if (!(bus.digit == 4'd0 && base_cnt == '0) && (base_cnt < DIG_CNT)) begin
                                bcd_d  = (base_bcd << 4) | (4*DIGITS)'(bus.digit);
                                disp_d = base_mag * MAG_W'(10) + MAG_W'(bus.digit);
                                cnt_d  = base_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ARITH: begin
                    fin     = 1'b1;
                    fin_mag = (2*MAG_W)'(arith_mag);
                    fin_neg = arith_neg;
                end
                MUL: begin
                    acc_d    = acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    step_d   = step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        fin     = 1'b1;
                        fin_mag = acc_nxt;
                        fin_neg = res_neg_q;
                    end
                end
                DIV: begin
                    rem_d  = rem_nx;
                    quo_d  = quo_nx;
                    step_d = step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        fin     = 1'b1;
                        fin_mag = (2*MAG_W)'(quo_nx);
                        fin_neg = res_neg_q;
                        fin_bad = (dvsr_q == '0);
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    bcd_d     = conv_bcd;
                    neg_d     = res_neg_q;
                    disp_d    = res_mag_q;
                    a_mag_d   = res_mag_q;
                    a_neg_d   = res_neg_q;
                    oper_d    = pend_q;
                    pend_d    = OP_NONE;
                    fresh_d   = 1'b1;
                    entered_d = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (launch) begin
                pend_d    = launch_pend;
                res_neg_d = a_neg_q ^ neg_q;
                step_d    = '0;
                case (oper_q)
                    OP_ADD, OP_SUB: state_d = ARITH;
                    OP_MUL: begin
                        acc_d    = '0;
                        mcand_d  = (2*MAG_W)'(a_mag_q);
                        mplier_d = disp_q;
                        state_d  = MUL;
                    end
                    OP_DIV: begin
                        rem_d   = '0;
                        quo_d   = a_mag_q;
                        dvsr_d  = disp_q;
                        state_d = DIV;
                    end
                    default: ;
                endcase
            end

            // results that cannot be shown bypass conversion and latch the error
            if (fin) begin
                if (fin_bad || (fin_mag > MAX_2W)) begin
                    err_d   = 1'b1;
                    bcd_d   = '0;
                    neg_d   = 1'b0;
                    disp_d  = '0;
                    fresh_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    res_mag_d  = fin_mag[MAG_W-1:0];
                    res_neg_d  = fin_neg && (fin_mag != '0);
                    conv_start = 1'b1;
                    conv_bin   = fin_mag[MAG_W-1:0];
                    state_d    = CONV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            oper_q    <= OP_NONE;
            pend_q    <= OP_NONE;
            a_mag_q   <= '0;
            a_neg_q   <= 1'b0;
            disp_q    <= '0;
            res_mag_q <= '0;
            res_neg_q <= 1'b0;
            cnt_q     <= '0;
            fresh_q   <= 1'b0;
            entered_q <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            oper_q    <= oper_d;
            pend_q    <= pend_d;
            a_mag_q   <= a_mag_d;
            a_neg_q   <= a_neg_d;
            disp_q    <= disp_d;
            res_mag_q <= res_mag_d;
            res_neg_q <= res_neg_d;
            cnt_q     <= cnt_d;
            fresh_q   <= fresh_d;
            entered_q <= entered_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            step_q    <= step_d;
        end
    end

    assign bus.bcd          = bcd_q;
    assign bus.negative     = neg_q;
    assign bus.oper_latched = oper_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine (DIGITS=3, MAG_W=10).
// Keystrokes are given as strings: digits, + - * / for operators, ~ for NEG,
// = for equals, C for clear.
module tb_calc_engine;
    import calc_pkg::*;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned MAG_W  = 10;

    logic clk = 1'b0;
    logic rst_n;

    calc_engine_if #(.DIGITS(DIGITS)) bus ();

    calc_engine #(
        .DIGITS (DIGITS),
        .MAG_W  (MAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.oper_valid  = 1'b0;
        bus.oper        = 3'd0;
        bus.equals      = 1'b0;
        bus.clear       = 1'b0;
    endtask

    // counts busy cycles, sampled at negedges, until the engine is idle
    task automatic wait_idle();
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (bus.busy) check("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    // one-cycle pulse for a single key
    task automatic press(input byte c);
        @(negedge clk);
        case (c)
            "+":     begin bus.oper_valid = 1'b1; bus.oper = OP_ADD; end
            "-":     begin bus.oper_valid = 1'b1; bus.oper = OP_SUB; end
            "*":     begin bus.oper_valid = 1'b1; bus.oper = OP_MUL; end
            "/":     begin bus.oper_valid = 1'b1; bus.oper = OP_DIV; end
            "~":     begin bus.oper_valid = 1'b1; bus.oper = OP_NEG; end
            "=":     bus.equals = 1'b1;
            "C":     bus.clear  = 1'b1;
            default: begin bus.digit_valid = 1'b1; bus.digit = 4'(c - 8'h30); end
        endcase
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            press(s[i]);
            wait_idle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd",  32'(bus.bcd), 32'h000);
        check("rst_neg",  32'(bus.negative), 32'd0);
        check("rst_oper", 32'(bus.oper_latched), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err",  32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // entry, leading zero dropped
        keys("012");
        check("entry_bcd", 32'(bus.bcd), 32'h012);
        keys("+");
        check("add_latched", 32'(bus.oper_latched), 32'd1);
        check("add_keeps_disp", 32'(bus.bcd), 32'h012);
        keys("34");
        check("operand_b", 32'(bus.bcd), 32'h034);
        keys("=");
        check("add_busy_cycles", 32'(busy_cycles), 32'(1 + MAG_W + 1));
        check("add_bcd", 32'(bus.bcd), 32'h046);
        check("add_neg", 32'(bus.negative), 32'd0);
        check("add_oper_clr", 32'(bus.oper_latched), 32'd0);

        // excess digits dropped
        keys("C1234");
        check("entry_limit", 32'(bus.bcd), 32'h123);

        // negative result and NEG toggle
        keys("C7-9=");
        check("sub_bcd", 32'(bus.bcd), 32'h002);
        check("sub_neg", 32'(bus.negative), 32'd1);
        keys("~");
        check("neg_toggle", 32'(bus.negative), 32'd0);
        check("neg_bcd", 32'(bus.bcd), 32'h002);
        check("neg_oper", 32'(bus.oper_latched), 32'd0);

        // chaining
        keys("C2+3*");
        check("chain_partial", 32'(bus.bcd), 32'h005);
        check("chain_oper", 32'(bus.oper_latched), 32'd3);
        keys("4=");
        check("chain_bcd", 32'(bus.bcd), 32'h020);
        check("chain_oper_clr", 32'(bus.oper_latched), 32'd0);

        // operator replaced when no operand keyed
        keys("C3+-");
        check("op_replace", 32'(bus.oper_latched), 32'd2);
        keys("1=");
        check("op_replace_bcd", 32'(bus.bcd), 32'h002);

        // largest representable sum
        keys("C998+1=");
        check("max_bcd", 32'(bus.bcd), 32'h999);
        check("max_err", 32'(bus.err), 32'd0);

        // multiply overflow, sticky error
        keys("C999*2=");
        check("ovf_err", 32'(bus.err), 32'd1);
        check("ovf_bcd", 32'(bus.bcd), 32'h000);
        keys("5");
        check("err_ignores_digit", 32'(bus.bcd), 32'h000);
        check("err_sticky", 32'(bus.err), 32'd1);
        keys("C");
        check("clear_err", 32'(bus.err), 32'd0);

        // division, then divide by zero
        keys("25/4=");
        check("div_bcd", 32'(bus.bcd), 32'h006);
        check("div_neg", 32'(bus.negative), 32'd0);
        keys("100/0=");
        check("div0_err", 32'(bus.err), 32'd1);
        check("div0_bcd", 32'(bus.bcd), 32'h000);

        // sign of quotient, truncation toward zero
        keys("C7~/2=");
        check("sdiv_bcd", 32'(bus.bcd), 32'h003);
        check("sdiv_neg", 32'(bus.negative), 32'd1);

        // zero result is positive
        keys("C5~-5~=");
        check("zero_bcd", 32'(bus.bcd), 32'h000);
        check("zero_neg", 32'(bus.negative), 32'd0);

        // equals with nothing pending
        keys("C4=");
        check("eq_noop_bcd", 32'(bus.bcd), 32'h004);
        check("eq_noop_busy", 32'(bus.busy), 32'd0);

        // digit while busy is dropped
        keys("C2+3");
        press("=");
        press("9");
        wait_idle();
        check("busy_ignore", 32'(bus.bcd), 32'h005);

        // reset in the third DIV cycle
        keys("C25/4~");
        check("pre_rst_neg", 32'(bus.negative), 32'd1);
        check("pre_rst_oper", 32'(bus.oper_latched), 32'd4);
        @(negedge clk);
        bus.equals = 1'b1;
        @(negedge clk);
        bus.equals = 1'b0;
        check("div_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bcd",  32'(bus.bcd), 32'h000);
        check("midrst_neg",  32'(bus.negative), 32'd0);
        check("midrst_oper", 32'(bus.oper_latched), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_err",  32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        keys("6*7=");
        check("post_rst_mul", 32'(bus.bcd), 32'h042);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
